// File: rtl/pqr5_dmem_arbiter_if.sv
// Bus bundle between the two DMEM requesters, the arbiter and the single-port RAM.
// slave = arbiter side, master = requesters plus RAM model side.
interface pqr5_dmem_arbiter_if #(
    parameter int DSIZE = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 32
);
    localparam int BW  = DSIZE / 8;
    localparam int RAW = $clog2(DEPTH);

    logic             m0_valid;
    logic             m0_ready;
    logic             m0_we;
    logic [AW-1:0]    m0_addr;
    logic [BW-1:0]    m0_be;
    logic [DSIZE-1:0] m0_wdata;
    logic             m0_rvalid;
    logic [DSIZE-1:0] m0_rdata;
    logic             m0_rerr;

    logic             m1_valid;
    logic             m1_ready;
    logic             m1_we;
    logic [AW-1:0]    m1_addr;
    logic [BW-1:0]    m1_be;
    logic [DSIZE-1:0] m1_wdata;
    logic             m1_rvalid;
    logic [DSIZE-1:0] m1_rdata;
    logic             m1_rerr;
    logic             m1_lock;

    logic             ram_en;
    logic [BW-1:0]    ram_we;
    logic [RAW-1:0]   ram_addr;
    logic [DSIZE-1:0] ram_wdata;
    logic [DSIZE-1:0] ram_rdata;

    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_be, m0_wdata,
        output m0_ready, m0_rvalid, m0_rdata, m0_rerr,
        input  m1_valid, m1_we, m1_addr, m1_be, m1_wdata, m1_lock,
        output m1_ready, m1_rvalid, m1_rdata, m1_rerr,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_valid, m0_we, m0_addr, m0_be, m0_wdata,
        input  m0_ready, m0_rvalid, m0_rdata, m0_rerr,
        output m1_valid, m1_we, m1_addr, m1_be, m1_wdata, m1_lock,
        input  m1_ready, m1_rvalid, m1_rdata, m1_rerr,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/pqr5_dmem_arbiter.sv
// Round-robin arbiter sharing one DMEM RAM between core (port 0) and debug/loader (port 1).
// Define PQR5_DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module pqr5_dmem_arbiter #(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 32
) (
    input  logic                 clk,
    input  logic                 areset,
    pqr5_dmem_arbiter_if.slave   bus
`ifdef PQR5_DMEM_ARB_STATS_EN
    ,
    output logic [31:0]          m0_gnt_cnt,
    output logic [31:0]          m1_gnt_cnt,
    output logic [31:0]          conflict_cnt
`endif
);
    localparam int unsigned BW  = DSIZE / 8;
    localparam int unsigned RAW = $clog2(DEPTH);
    localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(DEPTH) << 2;

    typedef enum logic {StArb, StLock} state_e;

    state_e           r_state, w_state_next;
    logic             r_rr_ptr, w_rr_ptr_next;
    logic             w_arb, w_gnt0, w_gnt1, w_acc;
    logic             w_we, w_err, w_en;
    logic [AW-1:0]    w_addr;
    logic [BW-1:0]    w_be;
    logic [DSIZE-1:0] w_wdata;

    // One-entry response pipe: who owns the access issued last cycle.
    logic r_pv, r_owner, r_err, r_rd;

    always_comb begin
        // A locked state whose lock just dropped arbitrates normally this cycle.
        w_arb  = (r_state == StArb) || !bus.m1_lock;
        w_gnt0 = !areset && w_arb && bus.m0_valid && (!bus.m1_valid || !r_rr_ptr);
        w_gnt1 = !areset && bus.m1_valid && (!w_arb || !bus.m0_valid || r_rr_ptr);
        w_acc  = w_gnt0 || w_gnt1;

        w_state_next = ((w_gnt1 || r_state == StLock) && bus.m1_lock) ? StLock : StArb;
        w_rr_ptr_next = r_rr_ptr;
        if (w_gnt0) begin
            w_rr_ptr_next = 1'b1;
        end else if (w_gnt1) begin
            w_rr_ptr_next = 1'b0;
        end

        w_we    = w_gnt1 ? bus.m1_we    : bus.m0_we;
        w_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
        w_be    = w_gnt1 ? bus.m1_be    : bus.m0_be;
        w_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
        w_err   = (w_addr[1:0] != 2'b00) || ({1'b0, w_addr} >= ADDR_LIMIT);
        w_en    = w_acc && !w_err;
    end

    always_comb begin
        bus.m0_ready  = w_gnt0;
        bus.m1_ready  = w_gnt1;
        bus.ram_en    = w_en;
        bus.ram_we    = (w_en && w_we) ? w_be : '0;
        bus.ram_addr  = w_en ? w_addr[2 +: RAW] : '0;
        bus.ram_wdata = (w_en && w_we) ? w_wdata : '0;

        bus.m0_rvalid = r_pv && !r_owner;
        bus.m0_rerr   = bus.m0_rvalid && r_err;
        bus.m0_rdata  = (bus.m0_rvalid && r_rd && !r_err) ? bus.ram_rdata : '0;
        bus.m1_rvalid = r_pv && r_owner;
        bus.m1_rerr   = bus.m1_rvalid && r_err;
        bus.m1_rdata  = (bus.m1_rvalid && r_rd && !r_err) ? bus.ram_rdata : '0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state  <= StArb;
            r_rr_ptr <= 1'b0;
            r_pv     <= 1'b0;
            r_owner  <= 1'b0;
            r_err    <= 1'b0;
            r_rd     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_pv     <= w_acc;
            r_owner  <= w_gnt1;
            r_err    <= w_err;
            r_rd     <= !w_we;
        end
    end

`ifdef PQR5_DMEM_ARB_STATS_EN
    logic [31:0] r_m0_cnt, r_m1_cnt, r_conf_cnt;
    logic        w_conflict;

    // Both valid always leaves exactly one port stalled.
    assign w_conflict = !areset && bus.m0_valid && bus.m1_valid;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_m0_cnt   <= '0;
            r_m1_cnt   <= '0;
            r_conf_cnt <= '0;
        end else begin
            if (w_gnt0 && r_m0_cnt != '1) begin
                r_m0_cnt <= r_m0_cnt + 32'd1;
            end
            if (w_gnt1 && r_m1_cnt != '1) begin
                r_m1_cnt <= r_m1_cnt + 32'd1;
            end
            if (w_conflict && r_conf_cnt != '1) begin
                r_conf_cnt <= r_conf_cnt + 32'd1;
            end
        end
    end

    assign m0_gnt_cnt   = r_m0_cnt;
    assign m1_gnt_cnt   = r_m1_cnt;
    assign conflict_cnt = r_conf_cnt;
`endif
endmodule

// File: tb/tb_pqr5_dmem_arbiter.sv
// Directed vector bench for pqr5_dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_pqr5_dmem_arbiter;
    localparam int DEPTH = 1024;

    logic clk;
    logic areset;
    int   n_checks;
    int   n_errors;

    pqr5_dmem_arbiter_if #(.DSIZE(32), .DEPTH(DEPTH), .AW(32)) bus ();

`ifdef PQR5_DMEM_ARB_STATS_EN
    logic [31:0] m0_gnt_cnt, m1_gnt_cnt, conflict_cnt;
`endif

    pqr5_dmem_arbiter #(.DSIZE(32), .DEPTH(DEPTH), .AW(32)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
`ifdef PQR5_DMEM_ARB_STATS_EN
        ,
        .m0_gnt_cnt   (m0_gnt_cnt),
        .m1_gnt_cnt   (m1_gnt_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        logic v0; logic we0; logic [31:0] a0; logic [3:0] be0; logic [31:0] d0;
        logic v1; logic we1; logic [31:0] a1; logic [3:0] be1; logic [31:0] d1; logic lk;
        logic r0; logic r1; logic en; logic [3:0] rwe; logic [9:0] radr;
        logic rv0; logic [31:0] rd0; logic re0;
        logic rv1; logic [31:0] rd1; logic re1;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.m0_valid = v.v0; bus.m0_we = v.we0; bus.m0_addr = v.a0;
        bus.m0_be = v.be0; bus.m0_wdata = v.d0;
        bus.m1_valid = v.v1; bus.m1_we = v.we1; bus.m1_addr = v.a1;
        bus.m1_be = v.be1; bus.m1_wdata = v.d1; bus.m1_lock = v.lk;
    endtask

    task automatic set_idle();
        bus.m0_valid = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_be = '0; bus.m0_wdata = '0;
        bus.m1_valid = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_be = '0; bus.m1_wdata = '0;
        bus.m1_lock = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        // v0 we0 a0 be0 d0 | v1 we1 a1 be1 d1 lk || r0 r1 en rwe radr | rv0 rd0 re0 | rv1 rd1 re1
        vecs[0]  = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 0,
                     1, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 0,
                     0, 1, 1, 0, 8, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 0,
                     1, 0, 1, 0, 4, 0, 0, 0, 1, 0, 0};
        vecs[3]  = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 0,
                     0, 1, 1, 0, 8, 1, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 1, 'h10, 'hF, 'hDEADBEEF, 0, 0, 0, 0, 0, 0,
                     1, 0, 1, 'hF, 4, 0, 0, 0, 1, 0, 0};
        vecs[5]  = '{1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 1, 'h20, 'hF, 'hFFFFFFFF, 0,
                     0, 1, 1, 'hF, 8, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 1, 1, 'h20, 'h3, 'h12345678, 0,
                     0, 1, 1, 'h3, 8, 0, 0, 0, 1, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 0, 'h20, 0, 0, 0,
                     0, 1, 1, 0, 8, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{1, 0, 'h6, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFF5678, 0};
        vecs[11] = '{1, 0, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 'hFFC, 0, 0, 0,
                     0, 1, 1, 0, 'h3FF, 1, 0, 1, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[14] = '{1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 1,
                     0, 1, 1, 0, 8, 1, 'hDEADBEEF, 0, 0, 0, 0};
        vecs[16] = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 1,
                     0, 1, 1, 0, 8, 0, 0, 0, 1, 'hFFFF5678, 0};
        vecs[17] = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 1,
                     0, 1, 1, 0, 8, 0, 0, 0, 1, 'hFFFF5678, 0};
        vecs[18] = '{1, 0, 'h10, 0, 0, 1, 0, 'h20, 0, 0, 0,
                     1, 0, 1, 0, 4, 0, 0, 0, 1, 'hFFFF5678, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0};

        set_idle();
        areset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset m0_ready", 32'(bus.m0_ready), 0);
        check("reset m1_ready", 32'(bus.m1_ready), 0);
        check("reset ram_en", 32'(bus.ram_en), 0);
        check("reset ram_we", 32'(bus.ram_we), 0);
        check("reset m0_rvalid", 32'(bus.m0_rvalid), 0);
        check("reset m1_rvalid", 32'(bus.m1_rvalid), 0);
        @(negedge clk);
        areset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            #2;
            check($sformatf("v%0d m0_ready", i), 32'(bus.m0_ready), 32'(vecs[i].r0));
            check($sformatf("v%0d m1_ready", i), 32'(bus.m1_ready), 32'(vecs[i].r1));
            check($sformatf("v%0d ram_en", i), 32'(bus.ram_en), 32'(vecs[i].en));
            check($sformatf("v%0d ram_we", i), 32'(bus.ram_we), 32'(vecs[i].rwe));
            check($sformatf("v%0d ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].radr));
            check($sformatf("v%0d m0_rvalid", i), 32'(bus.m0_rvalid), 32'(vecs[i].rv0));
            check($sformatf("v%0d m0_rdata", i), bus.m0_rdata, vecs[i].rd0);
            check($sformatf("v%0d m0_rerr", i), 32'(bus.m0_rerr), 32'(vecs[i].re0));
            check($sformatf("v%0d m1_rvalid", i), 32'(bus.m1_rvalid), 32'(vecs[i].rv1));
            check($sformatf("v%0d m1_rdata", i), bus.m1_rdata, vecs[i].rd1);
            check($sformatf("v%0d m1_rerr", i), 32'(bus.m1_rerr), 32'(vecs[i].re1));
            @(negedge clk);
        end

        // Enter lock, then reset while a port-1 read is in flight.
        set_idle();
        bus.m1_valid = 1; bus.m1_addr = 'h20; bus.m1_lock = 1;
        #2;
        check("lock enter m1_ready", 32'(bus.m1_ready), 1);
        @(negedge clk);
        bus.m0_valid = 1; bus.m0_addr = 'h10;
        #2;
        check("locked m0_ready", 32'(bus.m0_ready), 0);
        check("locked m1_ready", 32'(bus.m1_ready), 1);
        @(posedge clk);
        #1 areset = 1'b1;
        #1;
        check("rst mid m1_rvalid", 32'(bus.m1_rvalid), 0);
        check("rst mid m0_rvalid", 32'(bus.m0_rvalid), 0);
        check("rst mid m1_rdata", bus.m1_rdata, 0);
        check("rst mid ram_en", 32'(bus.ram_en), 0);
        check("rst mid m0_ready", 32'(bus.m0_ready), 0);
        check("rst mid m1_ready", 32'(bus.m1_ready), 0);
        @(negedge clk);
        areset = 1'b0;
        #2;
        check("post rst m0_ready", 32'(bus.m0_ready), 1);
        check("post rst m1_ready", 32'(bus.m1_ready), 0);
        @(negedge clk);
        set_idle();
        #2;
        check("post rst m0_rvalid", 32'(bus.m0_rvalid), 1);
        check("post rst m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        check("post rst m1_rvalid", 32'(bus.m1_rvalid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
